// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies PLL lock, sequences system reset; define PLL_RETRY_EN
// to add lock-timeout PLL retries with a terminal FAIL after MAX_RETRIES.
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES  = 27000,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       sys_resetn_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] unlock_cnt_o
);
  localparam int TM1  = STABLE_CYCLES > LOCK_TIMEOUT ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX = TM1 > PLL_RST_CYCLES ? TM1 : PLL_RST_CYCLES;
  localparam int TW   = $clog2(TMAX);
`ifdef PLL_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic [TW-1:0] timer;
  logic [3:0] retry_nxt;
  logic [7:0] unlock_nxt;
  logic lock_s, timeout, exhausted;
  assign lock_s    = sync[1];
  // constant-folds away entirely when retries are not built
  assign timeout   = RETRY && timer == TW'(LOCK_TIMEOUT - 1);
  assign exhausted = retry_cnt_o >= 4'(MAX_RETRIES);
  always_comb begin
    nxt = state;
    retry_nxt = retry_cnt_o;
    unlock_nxt = unlock_cnt_o;
    case (state)
      PLL_RST: nxt = timer == TW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: begin
        nxt = lock_s ? STABLE : !timeout ? WAIT_LOCK : exhausted ? FAIL : PLL_RST;
        retry_nxt = retry_cnt_o + 4'(!lock_s && timeout && !exhausted);
      end
      STABLE: begin
        nxt = !lock_s ? WAIT_LOCK : timer == TW'(STABLE_CYCLES - 1) ? RUN : STABLE;
        retry_nxt = nxt == RUN ? 4'd0 : retry_cnt_o;
      end
      RUN: begin
        nxt = lock_s ? RUN : WAIT_LOCK;
        unlock_nxt = unlock_cnt_o + 8'(!lock_s && unlock_cnt_o != 8'hff);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync <= 2'b00;
      state <= PLL_RST;
      timer <= '0;
      pll_reset_o <= 1'b1;
      sys_resetn_o <= 1'b0;
      ready_o <= 1'b0;
      fail_o <= 1'b0;
      retry_cnt_o <= 4'd0;
      unlock_cnt_o <= 8'd0;
    end else begin
      sync <= {sync[0], lock_i};
      state <= nxt;
      timer <= nxt != state ? '0 : timer + TW'(1);
      pll_reset_o <= nxt == PLL_RST;
      sys_resetn_o <= nxt == RUN;
      ready_o <= nxt == RUN;
      fail_o <= nxt == FAIL;
      retry_cnt_o <= retry_nxt;
      unlock_cnt_o <= unlock_nxt;
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of lock qualification, lock loss, retry/FAIL
// (with PLL_RETRY_EN) or the no-retry wait (without it).
module tb_pll_lock_supervisor;
  logic clk = 1'b0;
  logic resetn, lock_i;
  logic pll_reset_o, sys_resetn_o, ready_o, fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] unlock_cnt_o;
  int vectors = 0;
  int miscompares = 0;
  int highs = 0;
  logic fail_seen = 1'b0;

  pll_lock_supervisor #(
    .STABLE_CYCLES(8), .LOCK_TIMEOUT(32), .PLL_RST_CYCLES(4), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .lock_i(lock_i),
    .pll_reset_o(pll_reset_o), .sys_resetn_o(sys_resetn_o), .ready_o(ready_o),
    .fail_o(fail_o), .retry_cnt_o(retry_cnt_o), .unlock_cnt_o(unlock_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pll"}, pll_reset_o, 1);
    chk({tag, "_sys"}, sys_resetn_o, 0);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_fail"}, fail_o, 0);
    chk({tag, "_retry"}, retry_cnt_o, 0);
    chk({tag, "_unlock"}, unlock_cnt_o, 0);
  endtask

  initial begin
    resetn = 1'b1;
    lock_i = 1'b1;
    #2 resetn = 1'b0;
    step(3);
    chk_reset("rst");
    // clean start: edge count e measured from release
    resetn = 1'b1;
    step(3);
    chk("clean_pll_e3", pll_reset_o, 1);
    step(1);
    chk("clean_pll_e4", pll_reset_o, 0);
    step(8);
    chk("clean_sys_e12", sys_resetn_o, 0);
    step(1);
    chk("clean_sys_e13", sys_resetn_o, 1);
    chk("clean_ready_e13", ready_o, 1);
    chk("clean_retry", retry_cnt_o, 0);
    // glitch in qualification
    resetn = 1'b0;
    #1 chk("async_rst_sys", sys_resetn_o, 0);
    chk("async_rst_pll", pll_reset_o, 1);
    step(2);
    resetn = 1'b1;
    step(8);
    lock_i = 1'b0;
    step(1);
    lock_i = 1'b1;
    step(4);
    chk("glitch_sys_e13", sys_resetn_o, 0);
    step(6);
    chk("glitch_sys_e19", sys_resetn_o, 0);
    step(1);
    chk("glitch_sys_e20", sys_resetn_o, 1);
    chk("glitch_retry", retry_cnt_o, 0);
    // loss in RUN
    lock_i = 1'b0;
    step(2);
    chk("loss_sys_k1", sys_resetn_o, 1);
    step(1);
    chk("loss_sys_k2", sys_resetn_o, 0);
    chk("loss_ready_k2", ready_o, 0);
    chk("loss_unlock1", unlock_cnt_o, 1);
    lock_i = 1'b1;
    step(10);
    chk("relock_sys_k9", sys_resetn_o, 0);
    step(1);
    chk("relock_sys_k10", sys_resetn_o, 1);
    chk("relock_unlock1", unlock_cnt_o, 1);
    for (int i = 2; i <= 300; i++) begin
      lock_i = 1'b0;
      step(3);
      lock_i = 1'b1;
      step(11);
      if (i == 254 || i == 255) chk($sformatf("unlock_%0d", i), unlock_cnt_o, 8'(i));
    end
    chk("unlock_sat", unlock_cnt_o, 255);
    chk("unlock_ready", ready_o, 1);
`ifdef PLL_RETRY_EN
    resetn = 1'b0;
    lock_i = 1'b0;
    step(2);
    resetn = 1'b1;
    step(3);
    chk("rty_pll_e3", pll_reset_o, 1);
    step(1);
    chk("rty_pll_e4", pll_reset_o, 0);
    step(31);
    chk("rty_pll_e35", pll_reset_o, 0);
    step(1);
    chk("rty_pll_e36", pll_reset_o, 1);
    chk("rty_retry_e36", retry_cnt_o, 1);
    step(3);
    chk("rty_pll_e39", pll_reset_o, 1);
    step(1);
    chk("rty_pll_e40", pll_reset_o, 0);
    step(31);
    chk("rty_pll_e71", pll_reset_o, 0);
    step(1);
    chk("rty_pll_e72", pll_reset_o, 1);
    chk("rty_retry_e72", retry_cnt_o, 2);
    step(4);
    chk("rty_pll_e76", pll_reset_o, 0);
    step(31);
    chk("rty_fail_e107", fail_o, 0);
    step(1);
    chk("rty_fail_e108", fail_o, 1);
    chk("rty_pll_e108", pll_reset_o, 0);
    chk("rty_retry_e108", retry_cnt_o, 2);
    lock_i = 1'b1;
    step(50);
    chk("fail_hold", fail_o, 1);
    chk("fail_hold_sys", sys_resetn_o, 0);
    chk("fail_hold_pll", pll_reset_o, 0);
`else
    resetn = 1'b0;
    lock_i = 1'b0;
    step(2);
    resetn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      highs += int'(pll_reset_o);
      fail_seen |= fail_o;
    end
    chk("norty_pulse", 8'(highs), 3);
    chk("norty_fail", fail_seen, 0);
    chk("norty_retry", retry_cnt_o, 0);
    chk("norty_sys", sys_resetn_o, 0);
    lock_i = 1'b1;
    step(10);
    chk("norty_sys_k9", sys_resetn_o, 0);
    step(1);
    chk("norty_sys_k10", sys_resetn_o, 1);
`endif
    resetn = 1'b0;
    #1 chk_reset("midrst");
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
